// File: rtl/uart_dpi.sv
// uart_dpi: 8-bit UART transceiver (start, 8 data LSB first, optional even parity, 1 stop).
// Define UART_DPI_PARITY_EN to add the even-parity bit in both directions.
module uart_dpi #(
    parameter int BAUD = 256000,
    parameter int FREQ = 100_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       tx_o,
    input  logic       rx_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_parity_err_o
);

    localparam int CPB = FREQ / BAUD;
    localparam int CW  = $clog2(CPB + 1);

    generate
        if (CPB < 4) begin : g_cpb_check
            $error("uart_dpi: FREQ/BAUD must be at least 4 clocks per bit");
        end
    endgenerate

`ifdef UART_DPI_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // ---------------- transmitter ----------------
    state_t          tx_state_reg;
    logic [CW-1:0]   tx_cnt_reg;
    logic [2:0]      tx_bit_reg;
    logic [7:0]      tx_shift_reg;
    logic            tx_par_reg;
    logic            tx_line_reg;
    logic            tx_ready_reg;
    logic            tx_bit_end;

    assign tx_bit_end = (tx_cnt_reg == CW'(CPB - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state_reg <= ST_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_line_reg  <= 1'b1;
            tx_ready_reg <= 1'b1;
        end else begin
            case (tx_state_reg)
                ST_IDLE: begin
                    if (tx_valid_i) begin
                        tx_shift_reg <= tx_data_i;
                        tx_par_reg   <= ^tx_data_i;
                        tx_line_reg  <= 1'b0;
                        tx_ready_reg <= 1'b0;
                        tx_cnt_reg   <= '0;
                        tx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg   <= '0;
                        tx_bit_reg   <= '0;
                        tx_line_reg  <= tx_shift_reg[0];
                        tx_state_reg <= ST_DATA;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg <= '0;
                        if (tx_bit_reg == 3'd7) begin
                            if (PAR_EN) begin
                                tx_line_reg  <= tx_par_reg;
                                tx_state_reg <= ST_PARITY;
                            end else begin
                                tx_line_reg  <= 1'b1;
                                tx_state_reg <= ST_STOP;
                            end
                        end else begin
                            // shift register keeps the next bit at position 0
                            tx_bit_reg   <= tx_bit_reg + 1'b1;
                            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                            tx_line_reg  <= tx_shift_reg[1];
                        end
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg   <= '0;
                        tx_line_reg  <= 1'b1;
                        tx_state_reg <= ST_STOP;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt_reg   <= '0;
                        tx_ready_reg <= 1'b1;
                        tx_state_reg <= ST_IDLE;
                    end else begin
                        tx_cnt_reg <= tx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    tx_cnt_reg   <= '0;
                    tx_line_reg  <= 1'b1;
                    tx_ready_reg <= 1'b1;
                    tx_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_o       = tx_line_reg;
    assign tx_ready_o = tx_ready_reg;

    // ---------------- receiver ----------------
    state_t          rx_state_reg;
    logic [CW-1:0]   rx_cnt_reg;
    logic [2:0]      rx_bit_reg;
    logic [7:0]      rx_shift_reg;
    logic            rx_par_bit_reg;
    logic            rx_sync1_reg;
    logic            rx_sync2_reg;
    logic            rx_prev_reg;
    logic [7:0]      rx_data_reg;
    logic            rx_valid_reg;
    logic            rx_ferr_reg;
    logic            rx_perr_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state_reg   <= ST_IDLE;
            rx_cnt_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_par_bit_reg <= 1'b0;
            rx_sync1_reg   <= 1'b1;
            rx_sync2_reg   <= 1'b1;
            rx_prev_reg    <= 1'b1;
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_ferr_reg    <= 1'b0;
            rx_perr_reg    <= 1'b0;
        end else begin
            rx_sync1_reg <= rx_i;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
            rx_valid_reg <= 1'b0;
            case (rx_state_reg)
                ST_IDLE: begin
                    // count starts at 2 because the edge was already visible one cycle ago
                    if (!rx_sync2_reg && rx_prev_reg) begin
                        rx_cnt_reg   <= CW'(2);
                        rx_state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt_reg == CW'(CPB / 2)) begin
                        rx_cnt_reg <= CW'(1);
                        rx_bit_reg <= '0;
                        rx_state_reg <= rx_sync2_reg ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_reg == CW'(CPB)) begin
                        rx_cnt_reg   <= CW'(1);
                        rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_reg <= PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            rx_bit_reg <= rx_bit_reg + 1'b1;
                        end
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (rx_cnt_reg == CW'(CPB)) begin
                        rx_cnt_reg     <= CW'(1);
                        rx_par_bit_reg <= rx_sync2_reg;
                        rx_state_reg   <= ST_STOP;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_reg == CW'(CPB)) begin
                        rx_cnt_reg   <= '0;
                        rx_valid_reg <= 1'b1;
                        rx_data_reg  <= rx_shift_reg;
                        rx_ferr_reg  <= !rx_sync2_reg;
                        rx_perr_reg  <= PAR_EN && (rx_par_bit_reg != (^rx_shift_reg));
                        rx_state_reg <= ST_IDLE;
                    end else begin
                        rx_cnt_reg <= rx_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    rx_cnt_reg   <= '0;
                    rx_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_data_o       = rx_data_reg;
    assign rx_valid_o      = rx_valid_reg;
    assign rx_frame_err_o  = rx_ferr_reg;
    assign rx_parity_err_o = rx_perr_reg;

endmodule

// File: tb/tb_uart_dpi.sv
// Self-checking bench for uart_dpi at CPB=10; parity checks follow UART_DPI_PARITY_EN.
module tb_uart_dpi;

    localparam int FREQ = 1_000_000;
    localparam int BAUD = 100_000;
    localparam int CPB  = FREQ / BAUD;
`ifdef UART_DPI_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int NBITS  = PAR_EN ? 11 : 10;
    localparam int FRAME  = NBITS * CPB;
    localparam int RX_LAT = 2 + CPB / 2 + (NBITS - 1) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_o;
    logic       rx_line;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         at_cyc;
    } rx_rec_t;
    rx_rec_t rx_q[$];

    assign rx_line = loop_en ? tx_o : rx_drv;

    uart_dpi #(.BAUD(BAUD), .FREQ(FREQ)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tx_o           (tx_o),
        .rx_i           (rx_line),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_ready_o     (tx_ready_o),
        .rx_data_o      (rx_data_o),
        .rx_valid_o     (rx_valid_o),
        .rx_frame_err_o (rx_frame_err_o),
        .rx_parity_err_o(rx_parity_err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid_o === 1'b1) begin
            rx_q.push_back('{rx_data_o, rx_frame_err_o, rx_parity_err_o, cyc});
            $display("rx  byte=%h ferr=%b perr=%b cyc=%0d", rx_data_o, rx_frame_err_o, rx_parity_err_o, cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line levels of one frame in transmission order: start, D0..D7, [parity], stop
    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b, input bit stop, input bit par_flip);
        logic [NBITS-1:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
        if (PAR_EN) f[9] = (^b) ^ par_flip;
        f[NBITS-1] = stop;
        return f;
    endfunction

    task automatic send_check(input logic [7:0] b, output int start_cyc);
        logic [NBITS-1:0] fb;
        logic exp_tx, exp_rdy;
        fb = frame_bits(b, 1'b1, 1'b0);
        start_cyc = 0;
        n_checks++;
        if (tx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_ready_before_send got %b want 1", tx_ready_o);
        end
        tx_data = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'($urandom);
        for (int j = 0; j <= FRAME; j++) begin
            @(negedge clk);
            if (j == 0) start_cyc = cyc;
            if (j == 5 * CPB) tx_valid = 1'b0;
            exp_tx  = (j < FRAME) ? fb[j / CPB] : 1'b1;
            exp_rdy = (j == FRAME);
            n_checks++;
            if (tx_o !== exp_tx || tx_ready_o !== exp_rdy) begin
                n_fail++;
                $display("FAIL tx_wave byte=%h j=%0d got tx=%b rdy=%b want tx=%b rdy=%b", b, j, tx_o, tx_ready_o, exp_tx, exp_rdy);
            end
        end
        tx_valid = 1'b0;
        $display("tx  byte=%h start_cyc=%0d", b, start_cyc);
    endtask

    task automatic drive_frame(input logic [7:0] b, input bit stop, input bit par_flip, output int fall_cyc);
        logic [NBITS-1:0] fb;
        fb = frame_bits(b, stop, par_flip);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        for (int i = 0; i < NBITS; i++) begin
            rx_drv = fb[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx(output bit ok, output rx_rec_t r);
        for (int i = 0; i < 3 * FRAME && rx_q.size() == 0; i++) @(negedge clk);
        ok = (rx_q.size() != 0);
        if (ok) r = rx_q.pop_front();
        else    r = '{8'h00, 1'b0, 1'b0, 0};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx got tx=%b rdy=%b want 1 1", tx_o, tx_ready_o);
        end
        n_checks++;
        if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00 || rx_frame_err_o !== 1'b0 || rx_parity_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rx got v=%b d=%h fe=%b pe=%b want 0 00 0 0", rx_valid_o, rx_data_o, rx_frame_err_o, rx_parity_err_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_tx_a5;
        int s;
        send_check(8'hA5, s);
    endtask

    task automatic check_rx(input string name, input logic [7:0] b, input bit ferr, input bit perr, input int exp_cyc);
        bit ok;
        rx_rec_t r;
        wait_rx(ok, r);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout got no rx_valid want byte %h", name, b);
        end else begin
            if (r.data !== b || r.ferr !== ferr || r.perr !== perr) begin
                n_fail++;
                $display("FAIL %s_data got %h fe=%b pe=%b want %h fe=%b pe=%b", name, r.data, r.ferr, r.perr, b, ferr, perr);
            end
            n_checks++;
            if (r.at_cyc != exp_cyc) begin
                n_fail++;
                $display("FAIL %s_latency got cyc %0d want %0d", name, r.at_cyc, exp_cyc);
            end
        end
    endtask

    task automatic test_back_to_back;
        int s1, s2;
        rx_q.delete();
        loop_en = 1'b1;
        send_check(8'h3C, s1);
        send_check(8'hFF, s2);
        n_checks++;
        if (s2 - s1 != FRAME + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing got %0d want %0d", s2 - s1, FRAME + 1);
        end
        check_rx("b2b_first", 8'h3C, 1'b0, 1'b0, s1 + RX_LAT);
        check_rx("b2b_second", 8'hFF, 1'b0, 1'b0, s2 + RX_LAT);
        repeat (CPB) @(posedge clk);
        #1;
        loop_en = 1'b0;
    endtask

    task automatic test_frame_err;
        int f;
        rx_q.delete();
        drive_frame(8'h81, 1'b0, 1'b0, f);
        check_rx("frame_err", 8'h81, 1'b1, 1'b0, f + RX_LAT);
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic test_glitch;
        int f;
        logic [7:0] b;
        rx_q.delete();
        @(posedge clk);
        #1;
        rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (2 * FRAME) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_no_strobe got %0d strobes want 0", rx_q.size());
        end
        b = 8'($urandom);
        drive_frame(b, 1'b1, 1'b0, f);
        check_rx("after_glitch", b, 1'b0, 1'b0, f + RX_LAT);
    endtask

    task automatic test_reset_midframe;
        int s;
        rx_q.delete();
        loop_en = 1'b1;
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (5 * CPB + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_o !== 1'b1 || tx_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe got tx=%b rdy=%b want 1 1", tx_o, tx_ready_o);
        end
        rst = 1'b0;
        repeat (2 * FRAME) @(negedge clk);
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_discard got %0d strobes want 0", rx_q.size());
        end
        send_check(8'h55, s);
        check_rx("after_reset", 8'h55, 1'b0, 1'b0, s + RX_LAT);
        repeat (CPB) @(posedge clk);
        #1;
        loop_en = 1'b0;
    endtask

    task automatic test_random_rx;
        int f;
        logic [7:0] b;
        bit stop, flip;
        for (int k = 0; k < 8; k++) begin
            rx_q.delete();
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            flip = PAR_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            drive_frame(b, stop, flip, f);
            check_rx("random_rx", b, !stop, PAR_EN ? flip : 1'b0, f + RX_LAT);
            repeat ($urandom_range(CPB, 3 * CPB)) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random_loopback;
        int s[4];
        logic [7:0] b[4];
        rx_q.delete();
        loop_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b[k] = 8'($urandom);
            send_check(b[k], s[k]);
        end
        for (int k = 0; k < 4; k++) check_rx("random_loop", b[k], 1'b0, 1'b0, s[k] + RX_LAT);
        repeat (CPB) @(posedge clk);
        #1;
        loop_en = 1'b0;
    endtask

`ifdef UART_DPI_PARITY_EN
    task automatic test_parity;
        int s, f;
        rx_q.delete();
        loop_en = 1'b1;
        send_check(8'h07, s);
        check_rx("parity_ok", 8'h07, 1'b0, 1'b0, s + RX_LAT);
        repeat (CPB) @(posedge clk);
        #1;
        loop_en = 1'b0;
        drive_frame(8'h07, 1'b1, 1'b1, f);
        check_rx("parity_bad", 8'h07, 1'b0, 1'b1, f + RX_LAT);
    endtask
`endif

    initial begin
        test_reset();
        test_tx_a5();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random_rx();
        test_random_loopback();
`ifdef UART_DPI_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
